// File: rtl/pipelined_cla_adder_pkg.sv
// pipelined_cla_adder_pkg: shared constants for the pipelined carry-lookahead adder
package pipelined_cla_adder_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_STAGES = 4;
    localparam int GRP_W = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/pipelined_cla_adder_cla_segment.sv
// cla_segment: combinational SEG_W-bit carry-lookahead adder built from 4-bit groups
module cla_segment
    import pipelined_cla_adder_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout
);
    localparam int NG = SEG_W / GRP_W;
    logic [SEG_W-1:0] p, g, c;
    logic [NG-1:0] gp, gg;
    logic [NG:0] gc;
    // group P/G, two-level lookahead for every group carry, then bit carries inside each group
    always_comb begin
        logic pp;
        p = a ^ b;
        g = a & b;
        gp = '0;
        gg = '0;
        gc = '0;
        c = '0;
        pp = 1'b0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < GRP_W; i++) begin
                gg[j] = g[j*GRP_W+i] | (p[j*GRP_W+i] & gg[j]);
                gp[j] = gp[j] & p[j*GRP_W+i];
            end
        end
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j];
            pp = gp[j];
            for (int k = j - 1; k >= 0; k--) begin
                gc[j+1] = gc[j+1] | (pp & gg[k]);
                pp = pp & gp[k];
            end
            gc[j+1] = gc[j+1] | (pp & cin);
        end
        for (int j = 0; j < NG; j++) begin
            c[j*GRP_W] = gc[j];
            for (int i = 1; i < GRP_W; i++)
                c[j*GRP_W+i] = g[j*GRP_W+i-1] | (p[j*GRP_W+i-1] & c[j*GRP_W+i-1]);
        end
    end
    assign s = p ^ c;
    assign cout = gc[NG];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: segmented CLA add/sub, one segment per stage, valid/ready with full stall
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int SEG_W = WIDTH / STAGES;
    logic adv;
    logic [WIDTH-1:0] b_eff;
    assign b_eff = (sub == OP_SUB) ? ~b : b;
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    // each stage consumes the low segment of the operands it receives and forwards the rest
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * SEG_W;
        logic [RW-1:0] oa, ob;
        logic cin_k, vin_k, cout_k, vld, cy;
        logic [SEG_W-1:0] ss;
        logic [(k+1)*SEG_W-1:0] nsum, sr;
        if (k == 0) begin : g_in
            assign oa = a;
            assign ob = b_eff;
            assign cin_k = (sub == OP_SUB) ? 1'b1 : ci;
            assign vin_k = in_valid;
            assign nsum = ss;
        end else begin : g_mid
            assign oa = g_st[k-1].g_fw.ar;
            assign ob = g_st[k-1].g_fw.br;
            assign cin_k = g_st[k-1].cy;
            assign vin_k = g_st[k-1].vld;
            assign nsum = {ss, g_st[k-1].sr};
        end
        cla_segment #(.SEG_W(SEG_W)) u_seg (
            .a(oa[SEG_W-1:0]),
            .b(ob[SEG_W-1:0]),
            .cin(cin_k),
            .s(ss),
            .cout(cout_k)
        );
        // stage valid, carry and partial sum; bubbles move with data and everything holds on stall
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= 1'b0;
                cy <= 1'b0;
                sr <= '0;
            end else if (adv) begin
                vld <= vin_k;
                cy <= cout_k;
                sr <= nsum;
            end
        end
        if (k < STAGES - 1) begin : g_fw
            logic [RW-SEG_W-1:0] ar, br;
            // operand bits still to be added by later stages
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ar <= '0;
                    br <= '0;
                end else if (adv) begin
                    ar <= oa[RW-1:SEG_W];
                    br <= ob[RW-1:SEG_W];
                end
            end
        end else begin : g_last
            logic am, bm;
            // operand sign bits kept alongside the final sum for overflow detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    am <= 1'b0;
                    bm <= 1'b0;
                end else if (adv) begin
                    am <= oa[RW-1];
                    bm <= ob[RW-1];
                end
            end
        end
    end
    assign out_valid = g_st[STAGES-1].vld;
    assign s = g_st[STAGES-1].sr;
    assign co = g_st[STAGES-1].cy;
    assign ovf = (g_st[STAGES-1].g_last.am == g_st[STAGES-1].g_last.bm) && (s[WIDTH-1] != g_st[STAGES-1].g_last.am);
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: randomized and directed checks against an arithmetic reference model
module tb_pipelined_cla_adder;
    typedef struct packed {
        logic [31:0] s;
        logic co;
        logic ovf;
    } res_t;
    typedef struct packed {
        logic v;
        logic r;
        res_t d;
    } obs_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic ci;
        logic sub;
        res_t r;
    } vec_t;

    logic clk, rst, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
    logic [31:0] a, b, s;
    int n_tests = 0;
    int n_fail = 0;
    res_t exp_q[$];

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic m);
        res_t t;
        longint r;
        if (m) begin
            t.s = x - y;
            t.co = (x >= y);
            r = longint'($signed(x)) - longint'($signed(y));
        end else begin
            {t.co, t.s} = {1'b0, x} + {1'b0, y} + {32'd0, c};
            r = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        end
        t.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return t;
    endfunction

    task automatic rand_op();
        a = $urandom;
        b = $urandom;
        ci = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    // one clock: sample at mid-cycle, track accepted and consumed operations, move to edge+1
    task automatic tick(output obs_t o, output logic got, output res_t e);
        #4;
        o.v = out_valid;
        o.r = in_ready;
        o.d = {s, co, ovf};
        got = out_valid && out_ready;
        e = 'x;
        if (got && exp_q.size() > 0) e = exp_q.pop_front();
        if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        ci = 1'b0;
        sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, s, co, ovf} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b s=%h co=%b ovf=%b, want all zero", out_valid, s, co, ovf);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        vec_t v[6];
        obs_t o;
        logic got, seen;
        res_t e;
        int lat;
        v[0] = {32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        v[1] = {32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        v[2] = {32'h1234_5678, 32'h3531_5986, 1'b0, 1'b0, 32'h4765_AFFE, 1'b0, 1'b0};
        v[3] = {32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        v[4] = {32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        v[5] = {32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = v[i].a;
            b = v[i].b;
            ci = v[i].ci;
            sub = v[i].sub;
            in_valid = 1'b1;
            tick(o, got, e);
            in_valid = 1'b0;
            seen = 1'b0;
            lat = 0;
            for (int c = 1; c <= 12 && !seen; c++) begin
                tick(o, got, e);
                if (o.v) begin
                    seen = 1'b1;
                    lat = c;
                    n_tests++;
                    if (o.d !== v[i].r) begin
                        n_fail++;
                        $display("FAIL vector%0d_table: got %h want %h", i, o.d, v[i].r);
                    end
                    n_tests++;
                    if (o.d !== e) begin
                        n_fail++;
                        $display("FAIL vector%0d_model: got %h want %h", i, o.d, e);
                    end
                end
            end
            n_tests++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL vector%0d_latency: got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic got;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 4);
            rand_op();
            tick(o, got, e);
            if (i < 4) begin
                n_tests++;
                if (o.r !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready%0d: got %b want 1", i, o.r);
                end
            end
            n_tests++;
            if (o.v !== (i >= 4 && i <= 7)) begin
                n_fail++;
                $display("FAIL b2b_valid_cycle%0d: got %b want %b", i, o.v, (i >= 4 && i <= 7));
            end
            if (got) begin
                n_tests++;
                if (o.d !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got %h want %h", i, o.d, e);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic got;
        res_t e, held;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            rand_op();
            tick(o, got, e);
        end
        out_ready = 1'b0;
        rand_op();
        held = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            tick(o, got, e);
            n_tests++;
            if (o.r !== 1'b0 || o.v !== 1'b1 || o.d !== held) begin
                n_fail++;
                $display("FAIL stall%0d: got r=%b v=%b d=%h want r=0 v=1 d=%h", i, o.r, o.v, o.d, held);
            end
        end
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(o, got, e);
            in_valid = 1'b0;
            if (got) begin
                n++;
                n_tests++;
                if (o.d !== e) begin
                    n_fail++;
                    $display("FAIL bp_result%0d: got %h want %h", n, o.d, e);
                end
            end
        end
        n_tests++;
        if (n != 5 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d delivered %0d pending want 5 delivered 0 pending", n, exp_q.size());
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic got;
        res_t e;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_op();
            if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            tick(o, got, e);
            n_tests++;
            if (o.r !== (!o.v || out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready%0d: got %b want %b", i, o.r, (!o.v || out_ready));
            end
            if (got) begin
                n_tests++;
                if (o.d !== e) begin
                    n_fail++;
                    $display("FAIL rand_result%0d: got %h want %h", i, o.d, e);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(o, got, e);
            if (got) begin
                n_tests++;
                if (o.d !== e) begin
                    n_fail++;
                    $display("FAIL rand_drain%0d: got %h want %h", i, o.d, e);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_lost: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic got;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            rand_op();
            tick(o, got, e);
        end
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre_valid: got %b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, s, co, ovf} !== 35'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%b s=%h co=%b ovf=%b want all zero", out_valid, s, co, ovf);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            tick(o, got, e);
            n_tests++;
            if (o.v !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stale%0d: got valid %b want 0", i, o.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
